// File: rtl/alu_op_sequencer.sv
// Initiator for the combinational ALU. It registers one operation, holds the ALU inputs for a settle
// window, captures the ALU outputs and returns them on a valid/ready response channel.
module alu_op_sequencer #(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [2:0]       req_cmd,

   output logic [WIDTH-1:0] alu_operandA,
   output logic [WIDTH-1:0] alu_operandB,
   output logic [2:0]       alu_command,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carryout,
   input  logic             alu_zero,
   input  logic             alu_overflow,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [2:0]       rsp_flags,
   output logic [2:0]       rsp_cmd,

   output logic             busy,
   output logic [15:0]      op_count
);

   // state      | meaning
   // ST_IDLE    | ready for a request, ALU inputs hold the last operation
   // ST_SETTLE  | ALU inputs frozen, counting down the propagation window
   // ST_RESPOND | captured result offered on the response channel
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   // Terminal count is zero, so loading SETTLE_CYCLES-1 places the capture
   // exactly SETTLE_CYCLES edges after the accept edge.
   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [WIDTH-1:0]   alu_b_q, alu_b_d;
   logic [2:0]         alu_cmd_q, alu_cmd_d;
   logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
   logic [2:0]         rsp_flags_q, rsp_flags_d;
   logic [2:0]         rsp_cmd_q, rsp_cmd_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [15:0]        op_count_q, op_count_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_cmd_d    = alu_cmd_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_cmd_d    = rsp_cmd_q;
      rsp_valid_d  = rsp_valid_q;
      op_count_d   = op_count_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               alu_a_d   = req_a;
               alu_b_d   = req_b;
               alu_cmd_d = req_cmd;
               rsp_cmd_d = req_cmd;
               cnt_d     = CNT_LOAD;
               state_d   = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               rsp_result_d = alu_result;
               rsp_flags_d  = {alu_overflow, alu_zero, alu_carryout};
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESPOND;
            end
         end
         ST_RESPOND: begin
            // Returning to IDLE here means a request waiting on this edge is taken one edge later.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               op_count_d  = op_count_q + 16'd1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 8'd0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_cmd_q    <= 3'd0;
         rsp_result_q <= '0;
         rsp_flags_q  <= 3'd0;
         rsp_cmd_q    <= 3'd0;
         rsp_valid_q  <= 1'b0;
         op_count_q   <= 16'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cmd_q    <= alu_cmd_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_cmd_q    <= rsp_cmd_d;
         rsp_valid_q  <= rsp_valid_d;
         op_count_q   <= op_count_d;
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign alu_operandA = alu_a_q;
   assign alu_operandB = alu_b_q;
   assign alu_command  = alu_cmd_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_result   = rsp_result_q;
   assign rsp_flags    = rsp_flags_q;
   assign rsp_cmd      = rsp_cmd_q;
   assign op_count     = op_count_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 32-bit ALU command interface: accepts one operation request per transaction and drives operandA, operandB and the 3-bit command into the combinational ALU.
- Holds those inputs stable for a parameterised settle window, because the gate-level ALU has long propagation delays.
- Then captures result, carryout, zero and overflow into registers and returns them on a valid/ready response channel.
- Sits between the control path and the ALU instance; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- SETTLE_CYCLES, 4, clock edges between request accept and ALU output capture; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- req_cmd  input  3  ALU command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
- alu_operandA  output  WIDTH  registered operand A to the ALU.
- alu_operandB  output  WIDTH  registered operand B to the ALU.
- alu_command  output  3  registered command to the ALU.
- alu_result  input  WIDTH  ALU result.
- alu_carryout  input  1  ALU carryout.
- alu_zero  input  1  ALU zero flag.
- alu_overflow  input  1  ALU overflow.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  captured result.
- rsp_flags  output  3  captured {overflow, zero, carryout}.
- rsp_cmd  output  3  command that produced this response.
- busy  output  1  high when state is not IDLE.
- op_count  output  16  completed-response counter.

Behaviour:
- **Reset** (async, rst_n=0): state=IDLE, all outputs 0 (alu_*, rsp_*, op_count, busy, rsp_valid); req_ready=1 once state is IDLE.
  - Mid-operation reset: rsp_valid and busy drop immediately, without waiting for a clock edge.
  - The in-flight operation is discarded and no response is produced.
- **State machine:** IDLE, SETTLE, RESPOND, with 8-bit down-counter cnt.
- **IDLE:** req_ready=1 (combinational from state only, never from req_valid).
  - On an edge with req_valid=1: alu_operandA<=req_a, alu_operandB<=req_b, alu_command<=req_cmd, rsp_cmd<=req_cmd, cnt<=SETTLE_CYCLES-1, go to SETTLE.
- **SETTLE:** req_ready=0; alu_* held constant.
  - Each edge: if cnt!=0, cnt<=cnt-1.
  - If cnt==0: rsp_result<=alu_result, rsp_flags<={alu_overflow, alu_zero, alu_carryout}, rsp_valid<=1, go to RESPOND.
- **Latency:** capture occurs exactly SETTLE_CYCLES edges after the accept edge; rsp_valid is high in the cycle following that edge.
- **RESPOND:** rsp_valid=1 and all rsp_* stable until handshake; alu_* still held.
  - On an edge with rsp_ready=1: rsp_valid<=0, op_count<=op_count+1, go to IDLE.
  - No new request is accepted on that same edge. Minimum request-to-request spacing is SETTLE_CYCLES+2 edges.
- **Backpressure:** rsp_ready may stay low indefinitely; the response is held with no loss and no overwrite.
- **Settle-window isolation:** ALU output changes during SETTLE before capture are ignored. ALU output changes during RESPOND do not alter rsp_*.
- **Idle inputs:** req_a/req_b/req_cmd changes while not in IDLE have no effect.
- **op_count:** wraps 0xFFFF -> 0x0000, no saturation.
- **busy:** equals (state != IDLE).
- **Scope:** no arithmetic inside the block; results come solely from the ALU inputs.

Test Plan:
- Reset, then ADD a=5, b=3 with SETTLE_CYCLES=4 against a behavioural ALU model -> alu_command=0 after accept edge; rsp_valid rises after edge 4; rsp_result=8, rsp_flags=000, rsp_cmd=0.
- SUB a=3, b=5 -> rsp_result=0xFFFFFFFE, rsp_flags carry=0, overflow=0. Then SUB a=0x7FFFFFFF, b=0xFFFFFFFF -> rsp_result=0x80000000, overflow=1.
- Backpressure: SLT a=0xFFFFFFFF, b=1 with rsp_ready held low for 10 cycles -> rsp_valid stays high, rsp_result=1 stable, req_ready=0 throughout, op_count unchanged until rsp_ready=1, then op_count=1.
- Model glitches alu_result to 0xDEADBEEF in SETTLE cycle 1, then settles to the correct value -> captured rsp_result is the settled value. Changing req_a during SETTLE leaves alu_operandA unchanged.
- Assert rst_n=0 mid-SETTLE, asynchronously between edges -> busy/rsp_valid go 0 immediately; after release req_ready=1, no spurious response, op_count=0.
- Preload op_count via 65535 back-to-back transactions with SETTLE_CYCLES=1 and rsp_ready=1 -> each takes 3 edges, op_count=0xFFFF; next completion -> op_count=0x0000.
